// File: rtl/pipe_addsub_pkg.sv
// rtl/pipe_addsub_pkg.sv - shared parameters, chunk derivation and flag layout for pipe_addsub
//
// Contents:
//   DEF_WIDTH / DEF_STAGES   default operand width and pipeline depth
//   chunk_width()            bits handled per pipeline stage
//   split_ok()               legality of a WIDTH/STAGES combination
//   FLAG_*                   bit positions inside the registered result-flag vector
package pipe_addsub_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  localparam int FLAG_COUT = 0;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_W    = 3;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_addsub_stage.sv
// rtl/pipe_addsub_stage.sv - combinational chunk adder for one pipeline stage
//
// Ports:
//   a_chunk, b_chunk  CHUNK-bit operand slices (b already inverted for subtract)
//   cin               carry into this chunk
//   sum_chunk         CHUNK-bit sum slice
//   cout              carry out of this chunk
//   ovf               signed-overflow term; meaningful only on the MSB chunk
module pipe_addsub_stage #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  input  logic             cin,
  output logic [CHUNK-1:0] sum_chunk,
  output logic             cout,
  output logic             ovf
);

  logic [CHUNK:0] total;

  assign total     = (CHUNK+1)'(a_chunk) + (CHUNK+1)'(b_chunk) + (CHUNK+1)'(cin);
  assign sum_chunk = total[CHUNK-1:0];
  assign cout      = total[CHUNK];

  // Same-sign operands producing a result of the other sign.
  assign ovf = (a_chunk[CHUNK-1] == b_chunk[CHUNK-1]) &&
               (sum_chunk[CHUNK-1] != a_chunk[CHUNK-1]);

endmodule

// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined WIDTH-bit add/subtract with carry chain split over STAGES
//
// Ports:
//   clk, reset                    clock (rising edge), asynchronous active-low reset
//   io_in_valid / io_in_ready     operand beat handshake
//   io_sub, io_cin                0 = add / 1 = subtract; carry-in or borrow-in
//   io_lhs, io_rhs                WIDTH-bit operands
//   io_out_valid / io_out_ready   result beat handshake
//   io_out                        WIDTH-bit result
//   io_cout, io_overflow, io_zero carry-or-borrow out, signed overflow, result == 0
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic             io_sub,
  input  logic             io_cin,
  input  logic [WIDTH-1:0] io_lhs,
  input  logic [WIDTH-1:0] io_rhs,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out,
  output logic             io_cout,
  output logic             io_overflow,
  output logic             io_zero
);

  localparam int C  = chunk_width(WIDTH, STAGES);
  localparam int L  = STAGES - 1;
  localparam int NP = (STAGES > 1) ? STAGES - 1 : 1;

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("pipe_addsub: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  // Intermediate stage registers (stages 0..STAGES-2); the last stage lands in the output registers.
  logic             p_v   [NP];
  logic             p_c   [NP];
  logic             p_sub [NP];
  logic [WIDTH-1:0] p_a   [NP];
  logic [WIDTH-1:0] p_b   [NP];
  logic [WIDTH-1:0] p_res [NP];

  logic              out_valid_q;
  logic [WIDTH-1:0]  out_q;
  logic [FLAG_W-1:0] flags_q;

  // Inputs seen by each stage's combinational adder, and what it produces.
  logic             s_v       [STAGES];
  logic             s_c       [STAGES];
  logic             s_sub     [STAGES];
  logic [WIDTH-1:0] s_a       [STAGES];
  logic [WIDTH-1:0] s_b       [STAGES];
  logic [WIDTH-1:0] s_res     [STAGES];
  logic [WIDTH-1:0] s_res_nxt [STAGES];
  logic [C-1:0]     s_sum     [STAGES];
  logic             s_cout    [STAGES];
  logic             s_ovf     [STAGES];

  logic advance;

  // One global enable: the whole pipe moves unless a held result is being refused.
  assign advance     = !out_valid_q || io_out_ready;
  assign io_in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Subtract is lhs + ~rhs + !cin; the borrow sense is restored at the output.
      assign s_v[k]   = io_in_valid;
      assign s_sub[k] = io_sub;
      assign s_a[k]   = io_lhs;
      assign s_b[k]   = io_sub ? ~io_rhs : io_rhs;
      assign s_c[k]   = io_cin ^ io_sub;
      assign s_res[k] = '0;
    end else begin : g_body
      assign s_v[k]   = p_v[k-1];
      assign s_sub[k] = p_sub[k-1];
      assign s_a[k]   = p_a[k-1];
      assign s_b[k]   = p_b[k-1];
      assign s_c[k]   = p_c[k-1];
      assign s_res[k] = p_res[k-1];
    end

    pipe_addsub_stage #(.CHUNK(C)) u_stage (
      .a_chunk   (s_a[k][k*C +: C]),
      .b_chunk   (s_b[k][k*C +: C]),
      .cin       (s_c[k]),
      .sum_chunk (s_sum[k]),
      .cout      (s_cout[k]),
      .ovf       (s_ovf[k])
    );

    // Chunks above k are still zero in the partial result, so OR-ing in the new slice is exact.
    assign s_res_nxt[k] = s_res[k] | (WIDTH'(s_sum[k]) << (k*C));
  end

  // Data registers only load with a real beat so bubbles leave the last result on the pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        p_v[k]   <= 1'b0;
        p_c[k]   <= 1'b0;
        p_sub[k] <= 1'b0;
        p_a[k]   <= '0;
        p_b[k]   <= '0;
        p_res[k] <= '0;
      end
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
    end else if (advance) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        p_v[k] <= s_v[k];
        if (s_v[k]) begin
          p_c[k]   <= s_cout[k];
          p_sub[k] <= s_sub[k];
          p_a[k]   <= s_a[k];
          p_b[k]   <= s_b[k];
          p_res[k] <= s_res_nxt[k];
        end
      end
      out_valid_q <= s_v[L];
      if (s_v[L]) begin
        out_q              <= s_res_nxt[L];
        flags_q[FLAG_COUT] <= s_cout[L] ^ s_sub[L];
        flags_q[FLAG_OVF]  <= s_ovf[L];
        flags_q[FLAG_ZERO] <= (s_res_nxt[L] == '0);
      end
    end
  end

  assign io_out_valid = out_valid_q;
  assign io_out       = out_q;
  assign io_cout      = flags_q[FLAG_COUT];
  assign io_overflow  = flags_q[FLAG_OVF];
  assign io_zero      = flags_q[FLAG_ZERO];

endmodule

// File: tb/tb_pipe_addsub.sv
// tb/tb_pipe_addsub.sv - directed self-checking bench for pipe_addsub (8/2, 32/4, 4/1)
module tb_pipe_addsub;

  logic        clk = 1'b0;
  logic        reset;
  logic        sub, cin, out_ready;
  logic [31:0] lhs, rhs;
  logic        v8, v32, v4;

  logic        r8, ov8, c8, f8, z8;
  logic [7:0]  o8;
  logic        r32, ov32, c32, f32, z32;
  logic [31:0] o32;
  logic        r4, ov4, c4, f4, z4;
  logic [3:0]  o4;

  int n_cmp = 0;
  int n_bad = 0;
  int sel = 0;

  logic        obs_v, obs_r, obs_c, obs_f, obs_z;
  logic [31:0] obs_out;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(8), .STAGES(2)) dut8 (
    .clk(clk), .reset(reset), .io_in_valid(v8), .io_in_ready(r8),
    .io_sub(sub), .io_cin(cin), .io_lhs(lhs[7:0]), .io_rhs(rhs[7:0]),
    .io_out_valid(ov8), .io_out_ready(out_ready), .io_out(o8),
    .io_cout(c8), .io_overflow(f8), .io_zero(z8)
  );

  pipe_addsub #(.WIDTH(32), .STAGES(4)) dut32 (
    .clk(clk), .reset(reset), .io_in_valid(v32), .io_in_ready(r32),
    .io_sub(sub), .io_cin(cin), .io_lhs(lhs), .io_rhs(rhs),
    .io_out_valid(ov32), .io_out_ready(out_ready), .io_out(o32),
    .io_cout(c32), .io_overflow(f32), .io_zero(z32)
  );

  pipe_addsub #(.WIDTH(4), .STAGES(1)) dut4 (
    .clk(clk), .reset(reset), .io_in_valid(v4), .io_in_ready(r4),
    .io_sub(sub), .io_cin(cin), .io_lhs(lhs[3:0]), .io_rhs(rhs[3:0]),
    .io_out_valid(ov4), .io_out_ready(out_ready), .io_out(o4),
    .io_cout(c4), .io_overflow(f4), .io_zero(z4)
  );

  always_comb begin
    obs_v = ov8; obs_r = r8; obs_c = c8; obs_f = f8; obs_z = z8; obs_out = {24'h0, o8};
    if (sel == 1) begin
      obs_v = ov32; obs_r = r32; obs_c = c32; obs_f = f32; obs_z = z32; obs_out = o32;
    end else if (sel == 2) begin
      obs_v = ov4; obs_r = r4; obs_c = c4; obs_f = f4; obs_z = z4; obs_out = {28'h0, o4};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input int d, input logic v);
    if (d == 0) v8 = v;
    else if (d == 1) v32 = v;
    else v4 = v;
  endtask

  // One isolated beat: result must appear exactly lat cycles after acceptance.
  task automatic run_vec(input int d, input int lat, input logic s, input logic c,
                         input logic [31:0] l, input logic [31:0] r,
                         input logic [31:0] e_out, input logic e_cout,
                         input logic e_ovf, input logic e_zero, input string tag);
    sel = d;
    @(negedge clk);
    sub = s; cin = c; lhs = l; rhs = r;
    set_valid(d, 1'b1);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i == 1) set_valid(d, 1'b0);
      if (i < lat) chk({tag, " early_valid"}, {31'h0, obs_v}, 32'h0);
    end
    chk({tag, " valid"}, {31'h0, obs_v}, 32'h1);
    chk({tag, " out"}, obs_out, e_out);
    chk({tag, " cout"}, {31'h0, obs_c}, {31'h0, e_cout});
    chk({tag, " ovf"}, {31'h0, obs_f}, {31'h0, e_ovf});
    chk({tag, " zero"}, {31'h0, obs_z}, {31'h0, e_zero});
  endtask

  logic [7:0] st_l [8];
  logic [7:0] st_r [8];
  logic [7:0] st_e [8];
  logic       st_c [8];
  logic       st_s [8];

  initial begin
    reset = 1'b0; sub = 1'b0; cin = 1'b0; lhs = '0; rhs = '0;
    out_ready = 1'b1; v8 = 1'b0; v32 = 1'b0; v4 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      chk($sformatf("reset%0d valid", d), {31'h0, obs_v}, 32'h0);
      chk($sformatf("reset%0d out", d), obs_out, 32'h0);
      chk($sformatf("reset%0d cout", d), {31'h0, obs_c}, 32'h0);
      chk($sformatf("reset%0d ovf", d), {31'h0, obs_f}, 32'h0);
      chk($sformatf("reset%0d zero", d), {31'h0, obs_z}, 32'h0);
      chk($sformatf("reset%0d in_ready", d), {31'h0, obs_r}, 32'h1);
    end

    run_vec(0, 2, 0, 0, 32'hFF, 32'h01, 32'h00, 1, 0, 1, "w8 add_ff_01");
    run_vec(0, 2, 0, 0, 32'h7F, 32'h01, 32'h80, 0, 1, 0, "w8 add_7f_01");
    run_vec(0, 2, 0, 1, 32'h0F, 32'h01, 32'h11, 0, 0, 0, "w8 add_0f_01_c1");
    run_vec(0, 2, 1, 0, 32'h05, 32'h07, 32'hFE, 1, 0, 0, "w8 sub_05_07");
    run_vec(0, 2, 1, 0, 32'h80, 32'h01, 32'h7F, 0, 1, 0, "w8 sub_80_01");
    run_vec(0, 2, 1, 1, 32'h10, 32'h10, 32'hFF, 1, 0, 0, "w8 sub_10_10_b1");
    run_vec(0, 2, 1, 0, 32'h00, 32'h00, 32'h00, 0, 0, 1, "w8 sub_00_00");

    run_vec(1, 4, 0, 1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1, 0, 1, "w32 add_ripple");
    run_vec(1, 4, 0, 0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1, 0, "w32 add_ovf");
    run_vec(1, 4, 1, 0, 32'h0, 32'h1, 32'hFFFF_FFFF, 1, 0, 0, "w32 sub_borrow");
    run_vec(1, 4, 1, 0, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 1, 0, "w32 sub_ovf");

    run_vec(2, 1, 0, 0, 32'hF, 32'h1, 32'h0, 1, 0, 1, "w4 add_f_1");
    run_vec(2, 1, 0, 0, 32'h7, 32'h1, 32'h8, 0, 1, 0, "w4 add_7_1");
    run_vec(2, 1, 1, 0, 32'h8, 32'h1, 32'h7, 0, 1, 0, "w4 sub_8_1");
    run_vec(2, 1, 1, 1, 32'h3, 32'h5, 32'hD, 1, 0, 0, "w4 sub_3_5_b1");

    // Back-to-back stream on the 8/2 instance.
    sel = 0;
    for (int i = 0; i < 8; i++) begin
      st_l[i] = 8'(i * 29 + 7);
      st_r[i] = 8'(43 + i);
      st_c[i] = i[0];
      st_s[i] = i[1];
      st_e[i] = st_s[i] ? 8'(st_l[i] - st_r[i] - 8'(st_c[i]))
                        : 8'(st_l[i] + st_r[i] + 8'(st_c[i]));
    end
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c >= 2 && c < 10) begin
        chk($sformatf("stream%0d valid", c - 2), {31'h0, obs_v}, 32'h1);
        chk($sformatf("stream%0d out", c - 2), obs_out, {24'h0, st_e[c-2]});
      end else begin
        chk($sformatf("stream idle%0d valid", c), {31'h0, obs_v}, 32'h0);
      end
      if (c < 8) begin
        v8 = 1'b1; sub = st_s[c]; cin = st_c[c];
        lhs = {24'h0, st_l[c]}; rhs = {24'h0, st_r[c]};
      end else begin
        v8 = 1'b0;
      end
    end

    // Backpressure: hold a valid result for 5 cycles with a third beat waiting.
    @(negedge clk);
    v8 = 1'b1; sub = 0; cin = 0; lhs = 32'h12; rhs = 32'h34;
    @(negedge clk);
    sub = 1; lhs = 32'h50; rhs = 32'h60;
    @(negedge clk);
    chk("bp first valid", {31'h0, obs_v}, 32'h1);
    chk("bp first out", obs_out, 32'h46);
    out_ready = 1'b0;
    sub = 0; cin = 1; lhs = 32'hF0; rhs = 32'h0F;
    #1;
    chk("bp in_ready low", {31'h0, obs_r}, 32'h0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d valid", j), {31'h0, obs_v}, 32'h1);
      chk($sformatf("bp hold%0d out", j), obs_out, 32'h46);
      chk($sformatf("bp hold%0d in_ready", j), {31'h0, obs_r}, 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", {31'h0, obs_r}, 32'h1);
    @(negedge clk);
    v8 = 1'b0;
    chk("bp second valid", {31'h0, obs_v}, 32'h1);
    chk("bp second out", obs_out, 32'hF0);
    chk("bp second cout", {31'h0, obs_c}, 32'h1);
    @(negedge clk);
    chk("bp third valid", {31'h0, obs_v}, 32'h1);
    chk("bp third out", obs_out, 32'h00);
    chk("bp third zero", {31'h0, obs_z}, 32'h1);
    @(negedge clk);
    chk("bp drained", {31'h0, obs_v}, 32'h0);

    // Reset with two beats in flight.
    @(negedge clk);
    v8 = 1'b1; sub = 0; cin = 0; lhs = 32'h01; rhs = 32'h01;
    @(negedge clk);
    lhs = 32'h02;
    @(negedge clk);
    v8 = 1'b0;
    chk("rst pre valid", {31'h0, obs_v}, 32'h1);
    chk("rst pre out", obs_out, 32'h02);
    reset = 1'b0;
    #1;
    chk("rst async valid", {31'h0, obs_v}, 32'h0);
    chk("rst async out", obs_out, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst in_ready", {31'h0, obs_r}, 32'h1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("rst no_stale%0d", j), {31'h0, obs_v}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
